// File: rtl/seq_mul_div_unit.sv
// seq_mul_div_unit: serial-load sequential multiply / restoring divide,
// signed or unsigned, with remainder, divide-by-zero and overflow flags.
//
// Ports:
//   clk, reset (async, active-low)
//   load/Data  : first load -> A, second load -> B (stored = 1)
//   start      : begin op (0 mul, 1 div) with sign (0 unsigned, 1 signed)
//   Result     : mul = product, div = {remainder, quotient}
//   ready/busy : result valid / operation in progress
//   div_by_zero, overflow : flags of the last operation
module seq_mul_div_unit #(
  parameter int WORD_LENGTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       start,
  input  logic                       op,
  input  logic                       sign,
  input  logic [WORD_LENGTH-1:0]     Data,
  output logic                       ready,
  output logic                       busy,
  output logic [2*WORD_LENGTH-1:0]   Result,
  output logic                       stored,
  output logic                       div_by_zero,
  output logic                       overflow
);

  localparam int W = WORD_LENGTH;
  localparam logic [W-1:0] LAST = W'(W - 1);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  logic [W-1:0]   a, b;
  logic           have_a;
  logic [W-1:0]   mag_a, mag_b;
  logic [W-1:0]   iter;
  logic           op_r;
  logic           neg_q, neg_r;
  logic           dz_r, ovf_r;
  logic [2*W-1:0] acc;

  logic           idle_ok, load_acc, start_acc, last;
  logic [W-1:0]   ma_in, mb_in;
  logic [W:0]     madd, shl;
  logic [W+1:0]   diff;
  logic [2*W-1:0] acc_mul, acc_div;
  logic [2*W-1:0] p_fix, fix_res;
  logic [W-1:0]   q_fix, r_fix;

  assign idle_ok   = (state == IDLE) || (state == DONE);
  assign load_acc  = load && idle_ok;
  assign start_acc = start && idle_ok && stored && !load;
  assign last      = (iter == LAST);
  assign busy      = (state == CALC) || (state == FIX);

  assign ma_in = (sign && a[W-1]) ? -a : a;
  assign mb_in = (sign && b[W-1]) ? -b : b;

  // Shift-add: low half holds the multiplier, consumed LSB first.
  assign madd    = {1'b0, acc[2*W-1:W]}
                 + (acc[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
  assign acc_mul = {madd, acc[W-1:1]};

  // Restoring divide: high half is the partial remainder, low half
  // shifts dividend bits out and quotient bits in.
  assign shl     = {acc[2*W-1:W], acc[W-1]};
  assign diff    = {1'b0, shl} - {2'b00, mag_b};
  assign acc_div = {diff[W+1] ? shl[W-1:0] : diff[W-1:0],
                    acc[W-2:0], ~diff[W+1]};

  assign p_fix = neg_q ? -acc : acc;
  assign q_fix = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign r_fix = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_comb begin
    fix_res = p_fix;
    if (dz_r)
      fix_res = '1;
    else if (op_r)
      fix_res = {r_fix, q_fix};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // A divide by zero spends one cycle in CALC without iterating.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (load_acc)
          state_nx = IDLE;
        else if (start_acc)
          state_nx = CALC;
      end
      CALC: if (dz_r || last) state_nx = FIX;
      FIX:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a           <= '0;
      b           <= '0;
      have_a      <= 1'b0;
      stored      <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      iter        <= '0;
      op_r        <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
      acc         <= '0;
      Result      <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (load_acc) begin
      if (!have_a || stored) begin
        a      <= Data;
        have_a <= 1'b1;
        stored <= 1'b0;
      end else begin
        b      <= Data;
        stored <= 1'b1;
      end
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (start_acc) begin
      op_r        <= op;
      neg_q       <= sign && (a[W-1] ^ b[W-1]);
      neg_r       <= sign && a[W-1];
      mag_a       <= ma_in;
      mag_b       <= mb_in;
      acc         <= op ? {{W{1'b0}}, ma_in}
                        : {{W{1'b0}}, mb_in};
      dz_r        <= op && (b == '0);
      ovf_r       <= op && sign && (a == MIN) && (b == '1);
      iter        <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        CALC: begin
          iter <= iter + 1'b1;
          acc  <= op_r ? acc_div : acc_mul;
        end
        FIX: begin
          Result      <= fix_res;
          ready       <= 1'b1;
          div_by_zero <= dz_r;
          overflow    <= ovf_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div_unit.sv
// tb_seq_mul_div_unit: directed vectors for seq_mul_div_unit (W = 9)
// against an arithmetic reference model, compared every cycle.
module tb_seq_mul_div_unit;

  localparam int W = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic           load = 1'b0;
  logic           start = 1'b0;
  logic           op = 1'b0;
  logic           sign = 1'b0;
  logic [W-1:0]   Data = '0;
  logic           ready, busy, stored, div_by_zero, overflow;
  logic [2*W-1:0] Result;

  int n_chk = 0;
  int n_fail = 0;

  seq_mul_div_unit #(.WORD_LENGTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start),
    .op(op), .sign(sign), .Data(Data), .ready(ready), .busy(busy),
    .Result(Result), .stored(stored), .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: plain integer multiply / truncating divide.
  function automatic logic [2*W-1:0] ref_res(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic o, input logic s);
    longint sa, sb, p, q, r;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (!o) begin
      p = sa * sb;
      return p[2*W-1:0];
    end
    if (b == '0) return '1;
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  logic           m_have_a, m_stored, m_ready, m_dz, m_ovf;
  logic           p_dz, p_ovf;
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_res, p_res;
  int             m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_have_a <= 1'b0; m_stored <= 1'b0; m_ready <= 1'b0;
      m_dz <= 1'b0; m_ovf <= 1'b0; p_dz <= 1'b0; p_ovf <= 1'b0;
      m_a <= '0; m_b <= '0; m_res <= '0; p_res <= '0; m_cnt <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ready <= 1'b1; m_res <= p_res;
        m_dz <= p_dz; m_ovf <= p_ovf;
      end
    end else if (load) begin
      if (!m_have_a || m_stored) begin
        m_a <= Data; m_have_a <= 1'b1; m_stored <= 1'b0;
      end else begin
        m_b <= Data; m_stored <= 1'b1;
      end
      m_ready <= 1'b0; m_dz <= 1'b0; m_ovf <= 1'b0;
    end else if (start && m_stored) begin
      p_res <= ref_res(m_a, m_b, op, sign);
      p_dz  <= op && (m_b == '0);
      p_ovf <= op && sign && (m_a == 9'h100) && (m_b == 9'h1FF);
      m_cnt <= (op && (m_b == '0)) ? 2 : W + 1;
      m_ready <= 1'b0; m_dz <= 1'b0; m_ovf <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("ready", ready, m_ready);
      chk("busy", busy, m_cnt != 0);
      chk("stored", stored, m_stored);
      chk("Result", Result, m_res);
      chk("div_by_zero", div_by_zero, m_dz);
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk); load = 1'b1; Data = v;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic run(input string nm, input logic o, input logic s,
                     input int exp_lat, input logic [2*W-1:0] exp_res);
    int lat;
    @(negedge clk); start = 1'b1; op = o; sign = s;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!ready && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk(nm, Result, exp_res);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stored", stored, 0);
    chk("rst_Result", Result, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    #1 reset = 1'b1;

    do_load(9'd13);
    chk("one_operand", stored, 0);
    do_load(9'd11);
    chk("two_operands", stored, 1);
    run("umul", 1'b0, 1'b0, 10, 18'd143);

    do_load(9'h1F9); do_load(9'd5);
    run("smul", 1'b0, 1'b1, 10, 18'h3FFDD);
    run("smul_again", 1'b0, 1'b1, 10, 18'h3FFDD);

    do_load(9'h19C); do_load(9'd7);
    run("sdiv", 1'b1, 1'b1, 10, 18'h3FDF2);
    do_load(9'd100); do_load(9'd7);
    run("udiv", 1'b1, 1'b0, 10, {9'd2, 9'd14});

    do_load(9'd50); do_load(9'd0);
    run("div0", 1'b1, 1'b0, 2, 18'h3FFFF);
    chk("div0_flag", div_by_zero, 1);
    do_load(9'd100); do_load(9'd7);
    run("div_after0", 1'b1, 1'b0, 10, {9'd2, 9'd14});
    chk("div0_cleared", div_by_zero, 0);

    do_load(9'h100); do_load(9'h1FF);
    run("ovf", 1'b1, 1'b1, 10, {9'd0, 9'h100});
    chk("ovf_flag", overflow, 1);

    do_load(9'd5);
    chk("reload_clears", stored, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_ignored", busy, 0);

    do_load(9'd3);
    @(negedge clk); start = 1'b1; op = 1'b0; sign = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); load = 1'b1; start = 1'b1; Data = 9'd77;
    @(negedge clk); load = 1'b0; start = 1'b0;
    chk("busy_ignores", busy, 1);
    repeat (12) @(negedge clk);
    chk("busy_result", Result, 18'd15);
    chk("busy_stored", stored, 1);
    run("operands_kept", 1'b0, 1'b0, 10, 18'd15);

    @(negedge clk); load = 1'b1; start = 1'b1; Data = 9'd9;
    @(negedge clk); load = 1'b0; start = 1'b0;
    chk("load_wins_busy", busy, 0);
    chk("load_wins_stored", stored, 0);

    do_load(9'd6);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_stored", stored, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_Result", Result, 0);
    chk("midrst_flags", {div_by_zero, overflow}, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    do_load(9'd13);
    chk("after_rst_one", stored, 0);
    do_load(9'd11);
    run("after_rst", 1'b0, 1'b0, 10, 18'd143);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
